// File: rtl/array_initializer_mb.sv
// array_initializer_mb: sweeps INIT_VALUE across all rows of NUM_BANKS arrays after reset, then services range flushes
module array_initializer_mb #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROW_WIDTH = 8,
    parameter int NUM_BLOCKS = 4,
    parameter int NUM_BANKS = 2,
    parameter logic [ROW_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_halt,
    input  logic                  i_flush_req,
    input  logic [ADDR_WIDTH-1:0] i_flush_start,
    input  logic [ADDR_WIDTH-1:0] i_flush_end,
    input  logic [NUM_BANKS-1:0]  i_flush_bank_mask,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic [NUM_BANKS-1:0]  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic                  o_valid,
    output logic                  o_flush_ack,
    output logic                  o_busy,
    output logic                  o_init_complete,
    output logic                  o_ready
);
    typedef enum logic [1:0] {UNINIT = 2'd0, BUSY = 2'd1, READY = 2'd2} state_t;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] range_end, range_end_n, addr_n;
    logic [ROW_WIDTH-1:0] data_n;
    logic [NUM_BANKS-1:0] wen_n;
    logic [NUM_BLOCKS-1:0] wmask_n;
    logic valid_n, ack_n, accept, flush_go;
    assign accept = o_valid & i_mem_ready & ~i_halt;
    assign flush_go = (state == READY) & i_flush_req & (|i_flush_bank_mask) & ~i_halt;
    assign o_busy = state == BUSY;
    assign o_init_complete = state == READY;
    assign o_ready = o_init_complete & ~i_halt;
    always_comb begin
        state_n = state;
        range_end_n = range_end;
        addr_n = o_addr;
        data_n = o_data;
        wen_n = o_wen;
        wmask_n = o_wmask;
        valid_n = o_valid;
        ack_n = i_halt ? o_flush_ack : flush_go;
        if (!i_halt) begin
            case (state)
                UNINIT: begin
                    state_n = BUSY;
                    range_end_n = '1;
                    addr_n = '0;
                    data_n = INIT_VALUE;
                    wen_n = '1;
                    wmask_n = '1;
                    valid_n = 1'b1;
                end
                BUSY: if (accept) begin
                    addr_n = (o_addr == range_end) ? '0 : o_addr + ADDR_ONE;
                    if (o_addr == range_end) begin
                        state_n = READY;
                        data_n = '0;
                        wen_n = '0;
                        wmask_n = '0;
                        valid_n = 1'b0;
                    end
                end
                READY: if (flush_go) begin
                    state_n = BUSY;
                    range_end_n = i_flush_end;
                    addr_n = i_flush_start;
                    data_n = INIT_VALUE;
                    wen_n = i_flush_bank_mask;
                    wmask_n = '1;
                    valid_n = 1'b1;
                end
                default: begin
                    state_n = UNINIT;
                    range_end_n = '0;
                    addr_n = '0;
                    data_n = '0;
                    wen_n = '0;
                    wmask_n = '0;
                    valid_n = 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= UNINIT;
            range_end <= '0;
            o_addr <= '0;
            o_data <= '0;
            o_wen <= '0;
            o_wmask <= '0;
            o_valid <= 1'b0;
            o_flush_ack <= 1'b0;
        end else begin
            state <= state_n;
            range_end <= range_end_n;
            o_addr <= addr_n;
            o_data <= data_n;
            o_wen <= wen_n;
            o_wmask <= wmask_n;
            o_valid <= valid_n;
            o_flush_ack <= ack_n;
        end
    end
endmodule

// File: tb/tb_array_initializer_mb.sv
// tb_array_initializer_mb: directed scenario checks of init sweep, flushes, backpressure, halt and reset
module tb_array_initializer_mb;
    localparam int AW = 3;
    localparam int RW = 8;
    localparam int NB = 4;
    localparam int NK = 2;
    localparam logic [RW-1:0] IV = 8'hA5;
    logic clk = 1'b0, arst = 1'b1, i_halt = 1'b0, i_flush_req = 1'b0, i_mem_ready = 1'b1;
    logic [AW-1:0] i_flush_start = '0, i_flush_end = '0;
    logic [NK-1:0] i_flush_bank_mask = '0;
    logic [AW-1:0] o_addr;
    logic [RW-1:0] o_data;
    logic [NK-1:0] o_wen;
    logic [NB-1:0] o_wmask;
    logic o_valid, o_flush_ack, o_busy, o_init_complete, o_ready;
    int checks = 0, errors = 0;

    array_initializer_mb #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW), .NUM_BLOCKS(NB), .NUM_BANKS(NK), .INIT_VALUE(IV)) dut (
        .clk(clk), .arst(arst), .i_halt(i_halt), .i_flush_req(i_flush_req),
        .i_flush_start(i_flush_start), .i_flush_end(i_flush_end), .i_flush_bank_mask(i_flush_bank_mask),
        .i_mem_ready(i_mem_ready), .o_addr(o_addr), .o_data(o_data), .o_wen(o_wen), .o_wmask(o_wmask),
        .o_valid(o_valid), .o_flush_ack(o_flush_ack), .o_busy(o_busy),
        .o_init_complete(o_init_complete), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic test_reset;
        arst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_addr, o_data, o_wen, o_wmask, o_valid, o_flush_ack, o_busy, o_init_complete, o_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {o_addr, o_data, o_wen, o_wmask, o_valid, o_flush_ack, o_busy, o_init_complete, o_ready});
        end
    endtask

    task automatic test_init;
        arst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_init_complete} !==
                {1'b1, 3'(k), 2'b11, 4'hF, IV, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL init_write_%0d: got %0h expected %0h", k,
                         {o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_init_complete},
                         {1'b1, 3'(k), 2'b11, 4'hF, IV, 1'b1, 1'b0});
            end
            @(negedge clk);
        end
        checks++;
        if ({o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_init_complete, o_ready} !==
            {1'b0, 3'd0, 2'b00, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL init_done: got %0h expected %0h",
                     {o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_init_complete, o_ready},
                     {1'b0, 3'd0, 2'b00, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic do_reset;
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_flush(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [NK-1:0] m, input int n);
        i_flush_start = s;
        i_flush_end = e;
        i_flush_bank_mask = m;
        i_flush_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_flush_ack, o_busy, o_valid} !== 3'b111) begin
            errors++;
            $display("FAIL flush_accept_%0d_%0d: got %0b expected 111", s, e, {o_flush_ack, o_busy, o_valid});
        end
        i_flush_req = 1'b0;
        i_flush_start = ~s;
        i_flush_end = ~e;
        i_flush_bank_mask = ~m;
        for (int k = 0; k < n; k++) begin
            checks++;
            if ({o_valid, o_addr, o_wen, o_wmask, o_data, o_flush_ack} !== {1'b1, 3'(s + k), m, 4'hF, IV, 1'(k == 0)}) begin
                errors++;
                $display("FAIL flush_write_%0d_%0d_%0d: got %0h expected %0h", s, e, k,
                         {o_valid, o_addr, o_wen, o_wmask, o_data, o_flush_ack},
                         {1'b1, 3'(s + k), m, 4'hF, IV, 1'(k == 0)});
            end
            @(negedge clk);
        end
        checks++;
        if ({o_valid, o_busy, o_init_complete, o_wen, o_addr, o_flush_ack} !== {1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_done_%0d_%0d: got %0h expected %0h", s, e,
                     {o_valid, o_busy, o_init_complete, o_wen, o_addr, o_flush_ack},
                     {1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 1'b0});
        end
    endtask

    task automatic test_flush;
        do_flush(3'd5, 3'd6, 2'b10, 2);
    endtask

    task automatic test_wrap;
        do_flush(3'd6, 3'd1, 2'b01, 4);
        do_flush(3'd3, 3'd3, 2'b11, 1);
    endtask

    task automatic test_flush_ignored;
        int cnt;
        i_flush_bank_mask = 2'b00;
        i_flush_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({o_flush_ack, o_valid, o_init_complete} !== 3'b001) begin
                errors++;
                $display("FAIL zero_mask_%0d: got %0b expected 001", k, {o_flush_ack, o_valid, o_init_complete});
            end
        end
        i_flush_start = 3'd2;
        i_flush_end = 3'd2;
        i_flush_bank_mask = 2'b01;
        do_reset();
        for (cnt = 0; !o_init_complete && cnt < 20; cnt++) begin
            checks++;
            if ({o_flush_ack, o_valid, o_addr, o_wen} !== {1'b0, 1'b1, 3'(cnt), 2'b11}) begin
                errors++;
                $display("FAIL busy_req_%0d: got %0h expected %0h", cnt,
                         {o_flush_ack, o_valid, o_addr, o_wen}, {1'b0, 1'b1, 3'(cnt), 2'b11});
            end
            @(negedge clk);
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL busy_req_len: got %0d expected 8", cnt);
        end
        @(negedge clk);
        checks++;
        if ({o_flush_ack, o_valid, o_addr, o_wen} !== {1'b1, 1'b1, 3'd2, 2'b01}) begin
            errors++;
            $display("FAIL held_req_ack: got %0h expected %0h", {o_flush_ack, o_valid, o_addr, o_wen}, {1'b1, 1'b1, 3'd2, 2'b01});
        end
        i_flush_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_init_complete, o_flush_ack} !== 3'b010) begin
            errors++;
            $display("FAIL held_req_done: got %0b expected 010", {o_valid, o_init_complete, o_flush_ack});
        end
    endtask

    task automatic test_backpressure;
        int cnt, ea;
        do_reset();
        for (cnt = 0; !o_init_complete && cnt < 40; cnt++) begin
            ea = cnt < 3 ? cnt : (cnt <= 7 ? 3 : cnt - 4);
            checks++;
            if ({o_valid, o_addr} !== {1'b1, 3'(ea)}) begin
                errors++;
                $display("FAIL backpressure_%0d: got %0h expected %0h", cnt, {o_valid, o_addr}, {1'b1, 3'(ea)});
            end
            if (cnt == 3) i_mem_ready = 1'b0;
            if (cnt == 7) i_mem_ready = 1'b1;
            @(negedge clk);
        end
        i_mem_ready = 1'b1;
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL backpressure_len: got %0d expected 12", cnt);
        end
    endtask

    task automatic test_halt;
        arst = 1'b1;
        i_halt = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_valid, o_busy, o_init_complete, o_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL halt_uninit: got %0b expected 0000", {o_valid, o_busy, o_init_complete, o_ready});
        end
        i_halt = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_valid, o_addr} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL halt_pre: got %0h expected %0h", {o_valid, o_addr}, {1'b1, 3'd2});
        end
        i_halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_ready} !== {1'b1, 3'd2, 2'b11, 4'hF, IV, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL halt_freeze_%0d: got %0h expected %0h", k,
                         {o_valid, o_addr, o_wen, o_wmask, o_data, o_busy, o_ready},
                         {1'b1, 3'd2, 2'b11, 4'hF, IV, 1'b1, 1'b0});
            end
        end
        i_halt = 1'b0;
        @(negedge clk);
        checks++;
        if (o_addr !== 3'd3) begin
            errors++;
            $display("FAIL halt_resume: got %0d expected 3", o_addr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({o_init_complete, o_ready} !== 2'b11) begin
            errors++;
            $display("FAIL halt_done: got %0b expected 11", {o_init_complete, o_ready});
        end
        i_halt = 1'b1;
        #1;
        checks++;
        if ({o_init_complete, o_ready} !== 2'b10) begin
            errors++;
            $display("FAIL halt_ready_comb: got %0b expected 10", {o_init_complete, o_ready});
        end
        i_halt = 1'b0;
        i_flush_start = 3'd0;
        i_flush_end = 3'd1;
        i_flush_bank_mask = 2'b11;
        i_flush_req = 1'b1;
        @(negedge clk);
        i_flush_req = 1'b0;
        i_halt = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_flush_ack, o_valid, o_addr} !== {1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL halt_ack_hold: got %0h expected %0h", {o_flush_ack, o_valid, o_addr}, {1'b1, 1'b1, 3'd0});
        end
        i_halt = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_flush_ack, o_addr} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL halt_ack_release: got %0h expected %0h", {o_flush_ack, o_addr}, {1'b0, 3'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_arst_mid_flush;
        i_flush_start = 3'd4;
        i_flush_end = 3'd7;
        i_flush_bank_mask = 2'b01;
        i_flush_req = 1'b1;
        @(negedge clk);
        i_flush_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_valid, o_addr, o_wen} !== {1'b1, 3'd6, 2'b01}) begin
            errors++;
            $display("FAIL arst_pre: got %0h expected %0h", {o_valid, o_addr, o_wen}, {1'b1, 3'd6, 2'b01});
        end
        arst = 1'b1;
        #1;
        checks++;
        if ({o_addr, o_data, o_wen, o_wmask, o_valid, o_flush_ack, o_busy, o_init_complete} !== '0) begin
            errors++;
            $display("FAIL arst_async: got %0h expected 0",
                     {o_addr, o_data, o_wen, o_wmask, o_valid, o_flush_ack, o_busy, o_init_complete});
        end
        @(negedge clk);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_flush();
        test_wrap();
        test_flush_ignored();
        test_backpressure();
        test_halt();
        test_arst_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/array_initializer_mb.md
Name: array_initializer_mb

Overview:
- Parametrised successor to the single-array status initializer, sitting between reset/control logic and the status/tag SRAM banks of the instruction cache.
- After reset it writes INIT_VALUE to every row of NUM_BANKS parallel banks, then reports completion.
- It adds a run-time flush: re-initialise an address range on a chosen subset of banks.
- All writes use a valid/ready handshake with the memory port, so the array arbiter can apply backpressure.

Parameters:
ADDR_WIDTH, 6, row address width; depth = 2**ADDR_WIDTH
ROW_WIDTH, 8, data bits per row
NUM_BLOCKS, 4, write-mask bits per row
NUM_BANKS, 2, banks written in parallel (one write enable each)
INIT_VALUE, 0, ROW_WIDTH-bit pattern written to every row

Ports:
clk  input  1  clock
arst  input  1  asynchronous reset, active high
i_halt  input  1  stall: when 1, all state and outputs hold
i_flush_req  input  1  flush request, level; held by requester until o_flush_ack
i_flush_start  input  ADDR_WIDTH  first row of flush range
i_flush_end  input  ADDR_WIDTH  last row of flush range (inclusive)
i_flush_bank_mask  input  NUM_BANKS  banks to flush
i_mem_ready  input  1  memory port accepts the write this cycle
o_addr  output  ADDR_WIDTH  write row address
o_data  output  ROW_WIDTH  write data (always INIT_VALUE when valid)
o_wen  output  NUM_BANKS  per-bank write enable
o_wmask  output  NUM_BLOCKS  write mask (all ones when valid)
o_valid  output  1  write request valid
o_flush_ack  output  1  one-cycle pulse: flush request captured
o_busy  output  1  initialisation/flush in progress
o_init_complete  output  1  state == READY
o_ready  output  1  o_init_complete & ~i_halt (combinational)

Behaviour:
- Reset: while arst=1, all of the following are 0: o_addr, o_data, o_wen, o_wmask, o_valid, o_flush_ack, o_busy, o_init_complete. State is UNINIT and the counter is 0.
- States: UNINIT, BUSY, READY. Encoding is implementer's choice; illegal encodings go to UNINIT.
- UNINIT->BUSY on the first unhalted edge after arst falls. That edge loads:
  - range start=0, end=2**ADDR_WIDTH-1
  - bank mask all ones
  - o_addr=0, o_valid=1, o_wen=all ones, o_wmask=all ones, o_data=INIT_VALUE, o_busy=1.
- All write outputs are registered. o_busy, o_init_complete and o_flush_ack are registered/state-derived. o_ready is the only combinational output.
- A write is accepted on an edge where o_valid & i_mem_ready & ~i_halt.
  - If o_valid=1 and the write is not accepted, every write output holds stable (no change while stalled).
- On acceptance:
  - If o_addr != range end: o_addr <= o_addr+1, computed modulo 2**ADDR_WIDTH.
  - If o_addr == range end: o_valid, o_wen, o_wmask, o_data and o_addr all go to 0, o_busy goes to 0, and state becomes READY.
- Latency: with i_mem_ready=1 and no halt, a full init takes 2**ADDR_WIDTH consecutive valid cycles. o_init_complete rises on the edge that retires the last write.
- Flush acceptance: on an edge where state==READY & i_flush_req & |i_flush_bank_mask & ~i_halt.
  - Capture start, end and bank mask.
  - o_flush_ack=1 for exactly that next cycle.
  - State becomes BUSY with o_addr=start, o_wen=mask, o_valid=1.
- Flush edge cases:
  - A request with bank mask all zero is ignored and gets no ack.
  - Requests in UNINIT or BUSY are ignored and not acked; the requester keeps holding.
- Wrap-around: if start > end, the sweep runs start..2**ADDR_WIDTH-1, then 0..end. If start == end, exactly one row is written. Termination is on address equality only; the counter has no extra width.
- i_halt=1 freezes state, counter, captured range and all registered outputs. o_flush_ack, if high, stays high until the next unhalted edge. Unhalted behaviour resumes unchanged.
- arst asserted mid-BUSY (init or flush): outputs go immediately to reset values and the sweep is abandoned. After release, a full init restarts from row 0.
- The inputs i_flush_* are sampled only on the acceptance edge; changes during BUSY have no effect.

Test Plan:
- ADDR_WIDTH=3, NUM_BANKS=2, i_mem_ready=1: release arst -> o_valid high 8 cycles, o_addr 0..7, o_wen=2'b11, o_data=INIT_VALUE; o_init_complete rises on the edge retiring addr 7; then o_valid=0.
- Backpressure: drop i_mem_ready at addr 3 for 4 cycles -> o_addr holds 3, o_valid stays 1; resumes at 4; o_init_complete is delayed exactly 4 cycles.
- Flush in READY with start=5, end=6, mask=2'b10 -> o_flush_ack pulses once; writes addr 5 then 6 with o_wen=2'b10; back to READY with o_busy=0.
- Wrapped flush start=6, end=1, mask=2'b01 -> o_addr sequence 6,7,0,1 (4 writes). Flush with mask=0, or flush during BUSY -> no ack, no writes.
- i_halt=1 for 3 cycles at addr 2 with i_mem_ready=1 -> all outputs frozen, o_ready=0, no address advance; resumes at 2.
- arst pulsed while flushing at addr 6 -> outputs 0 immediately; after release, full init from addr 0 with o_wen=2'b11.
